// File: rtl/mc_control_unit_pkg.sv
// Shared definitions for the multi-cycle control unit.
//   state_t     : sequencer states
//   OP_*        : legal opcode values (low nibble of the opcode field)
//   ALU_*       : ALU operation codes, zero-extended by the user to ALUW
//   PC_SRC_*    : PC source select codes
package mc_control_unit_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_LD   = 4'd4;
  localparam logic [3:0] OP_ST   = 4'd5;
  localparam logic [3:0] OP_BEQ  = 4'd6;
  localparam logic [3:0] OP_JMP  = 4'd7;
  localparam logic [3:0] OP_ADDI = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  localparam logic [1:0] PC_SRC_INC = 2'd0;
  localparam logic [1:0] PC_SRC_BR  = 2'd1;
  localparam logic [1:0] PC_SRC_JMP = 2'd2;

  // Legality of the low nibble only; upper opcode bits are checked by the caller.
  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_ADDI) || (op == OP_HALT);
  endfunction

  // R-type opcodes map 1:1 onto ALU codes; BEQ compares by subtraction;
  // LD/ST/ADDI add an immediate.
  function automatic logic [1:0] alu_code(input logic [3:0] op);
    logic [1:0] code;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: code = op[1:0];
      OP_BEQ:                        code = ALU_SUB;
      default:                       code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Memory request/ready handshake between the control unit and memory.
//   mem_req      : request, held until mem_ready
//   mem_ready    : memory completes the current request this cycle
//   mem_write_en : data write (qualifies mem_req)
//   mem_op       : 0 = instruction fetch, 1 = data access
interface mc_control_unit_if;
  logic mem_req;
  logic mem_ready;
  logic mem_write_en;
  logic mem_op;

  modport master (output mem_req, output mem_write_en, output mem_op, input mem_ready);
  modport slave  (input mem_req, input mem_write_en, input mem_op, output mem_ready);
endinterface

// File: rtl/mc_control_unit_wait_timer.sv
// Memory wait counter with timeout compare.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_active     : sequencer is in a memory-waiting state (FETCH/MEM)
//   i_ready      : memory ready this cycle
//   o_timeout    : TMO-th consecutive not-ready cycle; sequencer traps next edge
module mc_wait_timer #(
  parameter int unsigned TMO = 15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_active,
  input  logic i_ready,
  output logic o_timeout
);

  localparam logic [7:0] LP_LAST = 8'(TMO - 1);

  logic [7:0] r_cnt;
  logic       w_waiting;

  assign w_waiting = i_active && !i_ready;
  // r_cnt holds the number of earlier not-ready cycles, so this cycle is
  // the TMO-th one when it equals TMO-1.
  assign o_timeout = w_waiting && (r_cnt == LP_LAST);

  // Any exit from the wait (ready, timeout, leaving the state) clears it.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_cnt <= '0;
    else if (w_waiting && !o_timeout)
      r_cnt <= r_cnt + 8'd1;
    else
      r_cnt <= '0;
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control unit: sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB and decodes datapath enables from the state.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_opcode       : instruction register opcode (stable DECODE..next FETCH)
//   i_zero         : ALU zero flag, used in EXEC for BEQ
//   mem            : memory handshake (master side)
//   o_ir_write, o_pc_write, o_pc_src, o_alu_sel, o_alu_src,
//   o_reg_write_en, o_mem_to_reg : datapath controls
//   o_halted, o_err : absorbing HALT / ERR indication
//   o_retired      : retired-instruction counter (wraps)
//
// state  | meaning
// FETCH  | instruction fetch request, wait for mem_ready
// DECODE | classify opcode; JMP and HALT finish here
// EXEC   | ALU operation; BEQ finishes here
// MEM    | data access request, wait for mem_ready; ST finishes here
// WB     | register writeback
// HALT   | halted until reset
// ERR    | illegal opcode or memory timeout, until reset
module mc_control_unit
  import mc_control_unit_pkg::*;
#(
  parameter int unsigned OPW  = 4,
  parameter int unsigned ALUW = 2,
  parameter int unsigned TMO  = 15,
  parameter int unsigned CNTW = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [OPW-1:0]    i_opcode,
  input  logic              i_zero,
  mc_control_unit_if.master mem,
  output logic              o_ir_write,
  output logic              o_pc_write,
  output logic [1:0]        o_pc_src,
  output logic [ALUW-1:0]   o_alu_sel,
  output logic              o_alu_src,
  output logic              o_reg_write_en,
  output logic              o_mem_to_reg,
  output logic              o_halted,
  output logic              o_err,
  output logic [CNTW-1:0]   o_retired
);

  state_t          r_state;
  logic [CNTW-1:0] r_retired;
  logic [3:0]      w_op;
  logic            w_op_hi_nz, w_legal, w_timeout, w_retire;
  logic            w_is_ld, w_is_st, w_is_beq, w_is_jmp, w_is_halt, w_is_addi;

  assign w_op = i_opcode[3:0];

  generate
    if (OPW > 4) begin : g_hi
      assign w_op_hi_nz = |i_opcode[OPW-1:4];
    end else begin : g_nohi
      assign w_op_hi_nz = 1'b0;
    end
  endgenerate

  assign w_legal   = !w_op_hi_nz && op_is_legal(w_op);
  assign w_is_ld   = (w_op == OP_LD);
  assign w_is_st   = (w_op == OP_ST);
  assign w_is_beq  = (w_op == OP_BEQ);
  assign w_is_jmp  = (w_op == OP_JMP);
  assign w_is_halt = (w_op == OP_HALT);
  assign w_is_addi = (w_op == OP_ADDI);

  mc_wait_timer #(.TMO(TMO)) u_wait_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_active  ((r_state == FETCH) || (r_state == MEM)),
    .i_ready   (mem.mem_ready),
    .o_timeout (w_timeout)
  );

  // Edge on which the final state of an instruction is left.
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      DECODE:  w_retire = w_legal && (w_is_jmp || w_is_halt);
      EXEC:    w_retire = w_is_beq;
      MEM:     w_retire = w_is_st && mem.mem_ready;
      WB:      w_retire = 1'b1;
      default: w_retire = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= FETCH;
      r_retired <= '0;
    end else begin
      case (r_state)
        FETCH:
          if (mem.mem_ready)  r_state <= DECODE;
          else if (w_timeout) r_state <= ERR;
        DECODE:
          if (!w_legal)       r_state <= ERR;
          else if (w_is_jmp)  r_state <= FETCH;
          else if (w_is_halt) r_state <= HALT;
          else                r_state <= EXEC;
        EXEC:
          if (w_is_beq)                r_state <= FETCH;
          else if (w_is_ld || w_is_st) r_state <= MEM;
          else                         r_state <= WB;
        MEM:
          if (mem.mem_ready)  r_state <= w_is_st ? FETCH : WB;
          else if (w_timeout) r_state <= ERR;
        WB:      r_state <= FETCH;
        HALT:    r_state <= HALT;
        ERR:     r_state <= ERR;
        default: r_state <= ERR;
      endcase
      if (w_retire) r_retired <= r_retired + 1'b1;
    end
  end

  // Outputs follow the registered state and opcode; the fetch strobes are
  // additionally qualified by the live mem_ready and BEQ's pc_write by zero.
  always_comb begin
    mem.mem_req      = 1'b0;
    mem.mem_op       = 1'b0;
    mem.mem_write_en = 1'b0;
    o_ir_write       = 1'b0;
    o_pc_write       = 1'b0;
    o_pc_src         = PC_SRC_INC;
    o_alu_sel        = '0;
    o_alu_src        = 1'b0;
    o_reg_write_en   = 1'b0;
    o_mem_to_reg     = 1'b0;
    o_halted         = 1'b0;
    o_err            = 1'b0;
    case (r_state)
      FETCH: begin
        mem.mem_req = 1'b1;
        o_ir_write  = mem.mem_ready && !i_rst;
        o_pc_write  = mem.mem_ready && !i_rst;
      end
      DECODE:
        if (w_legal && w_is_jmp) begin
          o_pc_write = 1'b1;
          o_pc_src   = PC_SRC_JMP;
        end
      EXEC: begin
        o_alu_sel = ALUW'(alu_code(w_op));
        o_alu_src = w_is_ld || w_is_st || w_is_addi;
        if (w_is_beq) begin
          o_pc_write = i_zero;
          o_pc_src   = PC_SRC_BR;
        end
      end
      MEM: begin
        mem.mem_req      = 1'b1;
        mem.mem_op       = 1'b1;
        mem.mem_write_en = w_is_st;
      end
      WB: begin
        o_reg_write_en = 1'b1;
        o_mem_to_reg   = w_is_ld;
      end
      HALT:    o_halted = 1'b1;
      ERR:     o_err    = 1'b1;
      default: o_err    = 1'b1;
    endcase
  end

  assign o_retired = r_retired;

endmodule

// File: tb/tb_mc_control_unit.sv
module tb_mc_control_unit;
  import mc_control_unit_pkg::*;

  localparam int OPW  = 5;
  localparam int ALUW = 2;
  localparam int TMO  = 15;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [OPW-1:0]  opcode;
  logic            zero;
  logic            ir_write, pc_write, alu_src, reg_write_en, mem_to_reg, halted, err;
  logic [1:0]      pc_src;
  logic [ALUW-1:0] alu_sel;
  logic [CNTW-1:0] retired;

  mc_control_unit_if u_mem ();

  mc_control_unit #(.OPW(OPW), .ALUW(ALUW), .TMO(TMO), .CNTW(CNTW)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_opcode       (opcode),
    .i_zero         (zero),
    .mem            (u_mem),
    .o_ir_write     (ir_write),
    .o_pc_write     (pc_write),
    .o_pc_src       (pc_src),
    .o_alu_sel      (alu_sel),
    .o_alu_src      (alu_src),
    .o_reg_write_en (reg_write_en),
    .o_mem_to_reg   (mem_to_reg),
    .o_halted       (halted),
    .o_err          (err),
    .o_retired      (retired)
  );

  always #5 clk = ~clk;

  // Field order: req op we irw pcw pcs alu asrc rwe m2r hlt err ret
  typedef struct packed {
    logic            req, mop, mwe, irw, pcw;
    logic [1:0]      pcs;
    logic [ALUW-1:0] alu;
    logic            asrc, rwe, m2r, hlt, err;
    logic [CNTW-1:0] ret;
  } obs_t;

  obs_t  exp_o, act_o;
  bit    exp_valid = 1'b0;
  string exp_tag   = "";
  int    checks    = 0;
  int    errors    = 0;

  // Model state: instructions retired and run/halt/error mode (0/1/2).
  int m_ret  = 0;
  int m_mode = 0;

  assign act_o = {u_mem.mem_req, u_mem.mem_op, u_mem.mem_write_en, ir_write, pc_write,
                  pc_src, alu_sel, alu_src, reg_write_en, mem_to_reg, halted, err, retired};

  always @(negedge clk) begin
    if (exp_valid) begin
      checks++;
      if (act_o !== exp_o) begin
        errors++;
        $display("FAIL %s @%0t got=%b expected=%b (req op we irw pcw pcs alu asrc rwe m2r hlt err ret)",
                 exp_tag, $time, act_o, exp_o);
      end
    end
  end

  function automatic obs_t base();
    obs_t o;
    o     = '0;
    o.ret = CNTW'(m_ret);
    o.hlt = (m_mode == 1);
    o.err = (m_mode == 2);
    return o;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  // One clock cycle: drive ready, publish the expectation, advance.
  task automatic step(input obs_t e, input logic rdy, input string tag);
    u_mem.mem_ready = rdy;
    exp_o     = e;
    exp_tag   = tag;
    exp_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    exp_valid       = 1'b0;
    rst             = 1'b1;
    u_mem.mem_ready = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst    = 1'b0;
    m_ret  = 0;
    m_mode = 0;
  endtask

  task automatic dead(input int n);
    obs_t e;
    for (int i = 0; i < n; i++) begin
      e = base();
      step(e, 1'($urandom_range(0, 1)), "dead");
    end
  endtask

  // Expected per-cycle schedule of one instruction, from the instruction rules.
  // nf/nm: not-ready cycles before fetch/data completion; stop_mem abandons it
  // after nm not-ready data cycles.
  task automatic run_instr(input logic [OPW-1:0] op, input logic z, input int nf,
                           input int nm, input bit stop_mem, output int ncyc);
    obs_t       e;
    logic [3:0] lo;
    logic [OPW-1:0] hi;
    bit         legal;
    lo    = op[3:0];
    hi    = op >> 4;
    legal = (hi == 0) && ((lo <= 4'd8) || (lo == 4'd15));
    ncyc  = 0;
    opcode = op;
    zero   = z;
    for (int i = 0; i < nf; i++) begin
      e = base(); e.req = 1;
      step(e, 1'b0, "fetch_wait"); ncyc++;
    end
    e = base(); e.req = 1; e.irw = 1; e.pcw = 1;
    step(e, 1'b1, "fetch"); ncyc++;
    e = base();
    if (legal && lo == 4'd7) begin e.pcw = 1; e.pcs = 2'd2; end
    step(e, 1'b1, "decode"); ncyc++;
    if (!legal)      begin m_mode = 2; return; end
    if (lo == 4'd7)  begin m_ret++; return; end
    if (lo == 4'd15) begin m_ret++; m_mode = 1; return; end
    e = base();
    e.alu  = (lo <= 4'd3) ? lo[1:0] : ((lo == 4'd6) ? 2'd1 : 2'd0);
    e.asrc = (lo == 4'd4) || (lo == 4'd5) || (lo == 4'd8);
    if (lo == 4'd6) begin e.pcw = z; e.pcs = 2'd1; end
    step(e, 1'b1, "exec"); ncyc++;
    if (lo == 4'd6) begin m_ret++; return; end
    if (lo == 4'd4 || lo == 4'd5) begin
      e = base(); e.req = 1; e.mop = 1; e.mwe = (lo == 4'd5);
      for (int i = 0; i < nm; i++) begin
        step(e, 1'b0, "mem_wait"); ncyc++;
      end
      if (stop_mem) return;
      step(e, 1'b1, "mem"); ncyc++;
      if (lo == 4'd5) begin m_ret++; return; end
    end
    e = base(); e.rwe = 1; e.m2r = (lo == 4'd4);
    step(e, 1'b1, "wb"); ncyc++;
    m_ret++;
  endtask

  initial begin
    logic [OPW-1:0] s_op[7];
    logic           s_z[7];
    int             s_lat[7];
    int             n;
    obs_t           e;

    s_op  = '{5'd0, 5'd4, 5'd5, 5'd7, 5'd6, 5'd6, 5'd15};
    s_z   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    s_lat = '{4, 5, 4, 2, 3, 3, 2};
    opcode = '0;
    zero   = 1'b0;

    // Reset and the instruction stream with ready tied high.
    do_reset(2);
    chk("reset_retired", int'(retired), 0);
    chk("reset_mem_req", int'(u_mem.mem_req), 1);
    chk("reset_err", int'(err), 0);
    for (int i = 0; i < 7; i++) begin
      run_instr(s_op[i], s_z[i], 0, 0, 1'b0, n);
      chk($sformatf("latency_%0d", i), n, s_lat[i]);
    end
    dead(3);
    chk("stream_retired", int'(retired), 7);
    chk("stream_halted", int'(halted), 1);

    // Reset while halted.
    do_reset(1);
    chk("rst_halt_req", int'(u_mem.mem_req), 1);
    chk("rst_halt_op", int'(u_mem.mem_op), 0);
    chk("rst_halt_halted", int'(halted), 0);
    chk("rst_halt_retired", int'(retired), 0);

    // Slow data and fetch memory, remaining ALU flavours.
    run_instr(5'd4, 1'b0, 0, 3, 1'b0, n);
    chk("ld_slow_latency", n, 8);
    run_instr(5'd1, 1'b0, 4, 0, 1'b0, n);
    run_instr(5'd2, 1'b1, 0, 0, 1'b0, n);
    run_instr(5'd3, 1'b0, 0, 0, 1'b0, n);
    run_instr(5'd8, 1'b0, 0, 0, 1'b0, n);
    run_instr(5'd6, 1'b1, 1, 0, 1'b0, n);

    // Reset in the middle of a data wait.
    run_instr(5'd5, 1'b0, 0, 2, 1'b1, n);
    do_reset(1);
    chk("rst_mem_req", int'(u_mem.mem_req), 1);
    chk("rst_mem_op", int'(u_mem.mem_op), 0);
    chk("rst_mem_we", int'(u_mem.mem_write_en), 0);
    chk("rst_mem_retired", int'(retired), 0);

    // Fetch timeout after TMO not-ready cycles.
    run_instr(5'd0, 1'b0, 0, 0, 1'b0, n);
    for (int i = 0; i < TMO; i++) begin
      e = base(); e.req = 1;
      step(e, 1'b0, "fetch_tmo");
    end
    m_mode = 2;
    dead(4);
    chk("fetch_tmo_err", int'(err), 1);
    chk("fetch_tmo_retired", int'(retired), 1);

    // Ready on the last allowed cycle completes; data timeout traps.
    do_reset(1);
    run_instr(5'd0, 1'b0, TMO - 1, 0, 1'b0, n);
    run_instr(5'd5, 1'b0, 0, TMO - 1, 1'b0, n);
    chk("late_ready_err", int'(err), 0);
    run_instr(5'd4, 1'b0, 0, TMO, 1'b1, n);
    m_mode = 2;
    dead(3);
    chk("mem_tmo_retired", int'(retired), 2);

    // Illegal opcodes.
    do_reset(1);
    run_instr(5'd12, 1'b0, 0, 0, 1'b0, n);
    dead(3);
    chk("illegal12_err", int'(err), 1);
    do_reset(1);
    run_instr(5'd16, 1'b0, 0, 0, 1'b0, n);
    dead(3);
    chk("illegal16_err", int'(err), 1);
    chk("illegal16_retired", int'(retired), 0);

    // Counter wrap with a 4-bit counter.
    do_reset(1);
    for (int i = 0; i < 17; i++) run_instr(5'd0, 1'b0, 0, 0, 1'b0, n);
    chk("wrap_model", m_ret % 16, 1);
    chk("wrap_retired", int'(retired), 1);

    exp_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
